// File: rtl/lp_filter_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed low-pass filter.
// Imported by the arbiter and the scheduler top.
package lp_filter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EMIT
    } state_t;

    localparam int MAX_W  = 64;
    localparam int MAX_CH = 16;

    // s + ((x - s) >>> sh), evaluated one bit wider than dw so the
    // difference keeps its sign; the result always lies between s and x.
    function automatic logic [MAX_W-1:0] stage_update(
        input logic [MAX_W-1:0] s,
        input logic [MAX_W-1:0] x,
        input int               dw,
        input int               sh
    );
        logic [MAX_W-1:0]   m;
        logic signed [MAX_W:0] d;
        m = (MAX_W'(1) << dw) - MAX_W'(1);
        d = $signed({1'b0, x & m}) - $signed({1'b0, s & m});
        return (s & m) + MAX_W'(d >>> sh);
    endfunction

    function automatic int rr_next(
        input logic [MAX_CH-1:0] pend,
        input int                ptr,
        input int                n
    );
        int  j;
        bit  found;
        rr_next = ptr;
        found   = 1'b0;
        for (int i = 1; i <= MAX_CH; i++) begin
            if (i <= n) begin
                j = ptr + i;
                if (j >= n) j = j - n;
                if (!found && pend[4'(j)]) begin
                    rr_next = j;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/lp_filter_scheduler_if.sv
// Sample-in / result-out bundle of the filter scheduler.
// master drives samples, slave is the scheduler.
interface lp_filter_scheduler_if #(
    parameter int CHANNELS  = 4,
    parameter int DATA_BITS = 28,
    parameter int CH_BITS   = $clog2(CHANNELS)
);
    logic [CHANNELS-1:0]           in_valid;
    logic [CHANNELS*DATA_BITS-1:0] in_value;
    logic                          out_valid;
    logic [CH_BITS-1:0]            out_channel;
    logic [DATA_BITS-1:0]          out_value;
    logic [CHANNELS-1:0]           overrun;
    logic                          busy;

    modport master (
        output in_valid, in_value,
        input  out_valid, out_channel, out_value, overrun, busy
    );

    modport slave (
        input  in_valid, in_value,
        output out_valid, out_channel, out_value, overrun, busy
    );
endinterface

// File: rtl/lp_filter_rr_arbiter.sv
// Round-robin picker over pending channels; search starts after the
// last granted channel, pointer advances only on an accepted grant.
module lp_filter_rr_arbiter
    import lp_filter_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CH_BITS  = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce,
    input  logic                req,
    input  logic [CHANNELS-1:0] pend,
    output logic [CHANNELS-1:0] gnt,
    output logic [CH_BITS-1:0]  idx,
    output logic                valid
);

    logic [CH_BITS-1:0] ptr;

    always_comb begin
        valid = |pend;
        idx   = CH_BITS'(rr_next(MAX_CH'(pend), int'(ptr), CHANNELS));
        gnt   = valid ? (CHANNELS'(1) << idx) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= CH_BITS'(CHANNELS - 1);
        end else if (ce && req && valid) begin
            ptr <= idx;
        end
    end

endmodule

// File: rtl/lp_filter_scheduler.sv
// Multi-channel cascaded first-order low-pass filter sharing one
// stage datapath; channels are serviced round-robin, one stage per cycle.
module lp_filter_scheduler
    import lp_filter_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int DATA_BITS   = 28,
    parameter int SHIFT_BITS  = 6,
    parameter int STAGE_COUNT = 4,
    parameter int CH_BITS     = $clog2(CHANNELS)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ce,
    lp_filter_scheduler_if.slave bus
);

    localparam int SC = (STAGE_COUNT > 0) ? STAGE_COUNT : 1;
    localparam int KB = (SC > 1) ? $clog2(SC) : 1;

    state_t state, state_nx;

    logic [CHANNELS-1:0]  pend;
    logic [CHANNELS-1:0]  primed;
    logic [CHANNELS-1:0]  ovr;
    logic [DATA_BITS-1:0] samp [CHANNELS];
    logic [DATA_BITS-1:0] st   [CHANNELS][SC];

    logic [DATA_BITS-1:0] x;
    logic [DATA_BITS-1:0] s_cur;
    logic [DATA_BITS-1:0] s_new;
    logic [CH_BITS-1:0]   ch;
    logic [KB-1:0]        k;

    logic [CHANNELS-1:0]  gnt;
    logic [CH_BITS-1:0]   gidx;
    logic                 gvalid;
    logic                 grant;
    logic                 last;

    logic                 ov;
    logic [CH_BITS-1:0]   och;
    logic [DATA_BITS-1:0] oval;

    lp_filter_rr_arbiter #(
        .CHANNELS (CHANNELS),
        .CH_BITS  (CH_BITS)
    ) u_arb (
        .clk   (clk),
        .rst_n (reset_n),
        .ce    (ce),
        .req   (state == IDLE),
        .pend  (pend),
        .gnt   (gnt),
        .idx   (gidx),
        .valid (gvalid)
    );

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        last     = (k == KB'(SC - 1));
        unique case (state)
            IDLE: begin
                if (gvalid) begin
                    grant    = 1'b1;
                    state_nx = (STAGE_COUNT == 0) ? EMIT : RUN;
                end
            end
            RUN: begin
                if (last) state_nx = EMIT;
            end
            EMIT: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // An unprimed channel seeds its stage with the raw input.
    always_comb begin
        s_cur = st[ch][k];
        s_new = x;
        if (primed[ch]) begin
            s_new = DATA_BITS'(stage_update(MAX_W'(s_cur), MAX_W'(x),
                                            DATA_BITS, SHIFT_BITS));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_nx;
        end
    end

    // A capture on the channel being granted keeps it pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend <= '0;
            ovr  <= '0;
            for (int c = 0; c < CHANNELS; c++) samp[c] <= '0;
        end else if (ce) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (bus.in_valid[c]) begin
                    if (pend[c] && !(grant && gnt[c])) ovr[c] <= 1'b1;
                    pend[c] <= 1'b1;
                    samp[c] <= bus.in_value[c*DATA_BITS +: DATA_BITS];
                end else if (grant && gnt[c]) begin
                    pend[c] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x      <= '0;
            ch     <= '0;
            k      <= '0;
            primed <= '0;
            ov     <= 1'b0;
            och    <= '0;
            oval   <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                for (int j = 0; j < SC; j++) st[c][j] <= '0;
            end
        end else if (ce) begin
            ov <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        ch <= gidx;
                        x  <= samp[gidx];
                        k  <= '0;
                    end
                end
                RUN: begin
                    st[ch][k] <= s_new;
                    x         <= s_new;
                    k         <= k + KB'(1);
                    if (last) primed[ch] <= 1'b1;
                end
                EMIT: begin
                    ov   <= 1'b1;
                    oval <= x;
                    och  <= ch;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.out_valid   = ov;
    assign bus.out_channel = och;
    assign bus.out_value   = oval;
    assign bus.overrun     = ovr;
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_lp_filter_scheduler.sv
// Directed bench for lp_filter_scheduler with a cycle-level reference
// model (countdown scheduler + integer filter math) checked every cycle.
module tb_lp_filter_scheduler;

    localparam int CH = 4;
    localparam int DW = 16;
    localparam int SH = 2;
    localparam int SC = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ce    = 1'b0;

    always #5 clk = ~clk;

    lp_filter_scheduler_if #(.CHANNELS(CH), .DATA_BITS(DW)) bus ();

    lp_filter_scheduler #(
        .CHANNELS    (CH),
        .DATA_BITS   (DW),
        .SHIFT_BITS  (SH),
        .STAGE_COUNT (SC)
    ) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .ce      (ce),
        .bus     (bus)
    );

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    bit          m_pend [CH];
    int          m_samp [CH];
    bit [CH-1:0] m_ovr;
    bit          m_prim [CH];
    int          m_s    [CH][SC];
    int          m_ptr, m_cnt, m_cur, m_res, m_och, m_oval, m_g, m_c;
    bit          m_ov;

    function automatic int fdiv(input int d);
        int q;
        q = d / (1 << SH);
        if (d < 0 && q * (1 << SH) != d) q = q - 1;
        return q;
    endfunction

    function automatic int filt(input int c, input int v);
        int xv;
        xv = v;
        for (int j = 0; j < SC; j++) begin
            if (m_prim[c]) xv = m_s[c][j] + fdiv(xv - m_s[c][j]);
            m_s[c][j] = xv;
        end
        m_prim[c] = 1'b1;
        return xv;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                m_pend[c] = 0;
                m_samp[c] = 0;
                m_prim[c] = 0;
                for (int j = 0; j < SC; j++) m_s[c][j] = 0;
            end
            m_ovr = '0;
            m_ptr = CH - 1;
            m_cnt = 0;
            m_ov  = 0;
            m_och = 0;
            m_oval = 0;
        end else if (ce) begin
            m_ov = 0;
            if (m_cnt == 0) begin
                m_g = -1;
                for (int i = 1; i <= CH; i++) begin
                    m_c = (m_ptr + i) % CH;
                    if (m_g < 0 && m_pend[m_c]) m_g = m_c;
                end
                if (m_g >= 0) begin
                    m_pend[m_g] = 0;
                    m_ptr = m_g;
                    m_cur = m_g;
                    m_res = filt(m_g, m_samp[m_g]);
                    m_cnt = SC + 1;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_ov   = 1;
                    m_och  = m_cur;
                    m_oval = m_res;
                end
            end
            for (int c = 0; c < CH; c++) begin
                if (bus.in_valid[c]) begin
                    if (m_pend[c]) m_ovr[c] = 1'b1;
                    m_pend[c] = 1;
                    m_samp[c] = int'(bus.in_value[c*DW +: DW]);
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("cmp_out_valid", bus.out_valid, m_ov);
            chk("cmp_out_channel", bus.out_channel, m_och);
            chk("cmp_out_value", bus.out_value, m_oval);
            chk("cmp_overrun", bus.overrun, m_ovr);
            chk("cmp_busy", bus.busy, m_cnt != 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_val(input int c, input int v);
        bus.in_value[c*DW +: DW] = DW'(v);
    endtask

    task automatic send(input int c, input int v, output int tcap);
        set_val(c, v);
        bus.in_valid[c] = 1'b1;
        tcap = cyc;
        @(negedge clk);
        bus.in_valid = '0;
    endtask

    task automatic wait_out(output int tout);
        bit got;
        got  = 0;
        tout = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                got  = 1;
                tout = cyc;
                break;
            end
        end
        chk("wait_out", got, 1);
    endtask

    int t0, t1, t2, t3;
    int oc [3];
    int ov [3];

    initial begin
        bus.in_valid = '0;
        bus.in_value = '0;
        ce    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_value", bus.out_value, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ptr", dut.u_arb.ptr, CH - 1);
        rst_n = 1'b1;
        @(negedge clk);

        // priming
        send(0, 1000, t0);
        wait_out(t1);
        chk("prime_latency", t1 - (t0 + 1), 4);
        chk("prime_channel", bus.out_channel, 0);
        chk("prime_value", bus.out_value, 1000);
        chk("prime_st0", dut.st[0][0], 1000);
        chk("prime_st1", dut.st[0][1], 1000);

        // filtering toward zero
        send(0, 0, t0);
        wait_out(t1);
        chk("filt1_value", bus.out_value, 937);
        chk("filt1_st0", dut.st[0][0], 750);
        chk("filt1_st1", dut.st[0][1], 937);
        send(0, 0, t0);
        wait_out(t1);
        chk("filt2_st0", dut.st[0][0], 562);
        chk("filt2_value", bus.out_value, 843);

        // round robin from pointer 1
        send(1, 200, t0);
        wait_out(t1);
        chk("rr_seed_value", bus.out_value, 200);
        chk("rr_ptr", dut.u_arb.ptr, 1);
        set_val(1, 600);
        set_val(2, 300);
        set_val(3, 400);
        bus.in_valid = 4'b1110;
        @(negedge clk);
        bus.in_valid = '0;
        wait_out(t1);
        oc[0] = int'(bus.out_channel);
        ov[0] = int'(bus.out_value);
        wait_out(t2);
        oc[1] = int'(bus.out_channel);
        ov[1] = int'(bus.out_value);
        wait_out(t3);
        oc[2] = int'(bus.out_channel);
        ov[2] = int'(bus.out_value);
        chk("rr_order0", oc[0], 2);
        chk("rr_order1", oc[1], 3);
        chk("rr_order2", oc[2], 1);
        chk("rr_gap01", t2 - t1, 4);
        chk("rr_gap12", t3 - t2, 4);
        chk("rr_ch2_value", ov[0], 300);
        chk("rr_ch1_value", ov[2], 225);

        // overrun on ch3 while ch0 runs
        send(0, 0, t0);
        @(negedge clk);
        set_val(3, 1000);
        bus.in_valid[3] = 1'b1;
        @(negedge clk);
        set_val(3, 2000);
        @(negedge clk);
        bus.in_valid = '0;
        chk("ovr_flag", bus.overrun, 4'b1000);
        wait_out(t1);
        chk("ovr_first_ch", bus.out_channel, 0);
        wait_out(t1);
        chk("ovr_ch3_ch", bus.out_channel, 3);
        chk("ovr_ch3_value", bus.out_value, 500);

        // clock-enable stall in RUN
        send(2, 700, t0);
        @(negedge clk);
        ce = 1'b0;
        @(negedge clk);
        bus.in_valid[1] = 1'b1;
        @(negedge clk);
        bus.in_valid = '0;
        repeat (2) @(negedge clk);
        chk("ce_st_frozen", dut.st[2][0], 300);
        chk("ce_busy_held", bus.busy, 1);
        @(negedge clk);
        ce = 1'b1;
        wait_out(t1);
        chk("ce_latency", t1 - (t0 + 1), 9);
        chk("ce_value", bus.out_value, 325);
        chk("ce_pulse_ignored", dut.pend, 0);

        // asynchronous reset mid-RUN
        send(1, 900, t0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_out_value", bus.out_value, 0);
        chk("arst_out_channel", bus.out_channel, 0);
        chk("arst_overrun", bus.overrun, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(0, 500, t0);
        wait_out(t1);
        chk("reprime_value", bus.out_value, 500);

        // capture coinciding with the ch3 grant
        send(3, 100, t0);
        set_val(3, 500);
        bus.in_valid[3] = 1'b1;
        @(negedge clk);
        bus.in_valid = '0;
        chk("coinc_pend3", dut.pend[3], 1);
        chk("coinc_overrun", bus.overrun, 0);
        wait_out(t1);
        chk("coinc_old_value", bus.out_value, 100);
        wait_out(t2);
        chk("coinc_new_value", bus.out_value, 125);
        chk("coinc_gap", t2 - t1, 4);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
